// File: rtl/image_stream_loader_pkg.sv
// Shared constants and state encoding for the image loader and the network top.
// Both sides import this package so that frame geometry and score layout always agree.
package image_stream_loader_pkg;

  localparam int DEF_NUM_PIXELS   = 784;
  localparam int DEF_PIX_W        = 16;
  localparam int DEF_NUM_CLASSES  = 10;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DONE_TIMEOUT = 1048576;
  localparam int DIGIT_W          = 4;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // The watchdog only has to count up to timeout-1, so clog2(timeout) bits are enough.
  function automatic int wdog_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/image_stream_loader_ram.sv
// Simple dual-port image RAM: one write port and one registered, read-first read port.
// The read timing matches the image ROM, so the network sees no difference.
module image_stream_loader_ram
  import image_stream_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_NUM_PIXELS,
  parameter int WIDTH  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rq
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rq <= '0;
    else     rq <= mem[raddr];
  end

endmodule

// File: rtl/image_stream_loader.sv
// Loads one frame into the image RAM, kicks the network, waits for done and reports the argmax.
//  state     | meaning
//  ST_LOAD   | accepting pixel beats, s_ready high
//  ST_START  | net_start pulse, watchdog cleared
//  ST_WAIT   | waiting for net_done, watchdog running
//  ST_ARGMAX | scanning one score lane per cycle
//  ST_REPORT | result_valid pulse, back to LOAD
module image_stream_loader
  import image_stream_loader_pkg::*;
#(
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int PIX_W        = DEF_PIX_W,
  parameter int NUM_CLASSES  = DEF_NUM_CLASSES,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [PIX_W-1:0]             s_data,
  input  logic                         s_last,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [PIX_W-1:0]             rd_q,
  output logic                         net_start,
  input  logic                         net_done,
  input  logic [NUM_CLASSES*PIX_W-1:0] digit_scores,
  output logic                         result_valid,
  output logic [DIGIT_W-1:0]           result_digit,
  output logic [PIX_W-1:0]             result_score,
  output logic                         busy,
  output logic                         frame_err,
  output logic                         timeout_err
);

  localparam int                WDOG_W    = wdog_width(DONE_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(DONE_TIMEOUT - 1);
  localparam logic [DIGIT_W-1:0] LAST_LANE = DIGIT_W'(NUM_CLASSES - 1);

  state_t              state;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [WDOG_W-1:0]   wdog;
  logic [DIGIT_W-1:0]  idx;
  logic [PIX_W-1:0]    score_q [NUM_CLASSES];
  logic [PIX_W-1:0]    best_score;
  logic [DIGIT_W-1:0]  best_idx;

  logic                beat;
  logic                at_end;
  logic                wdog_expired;
  logic [PIX_W-1:0]    lane;
  logic                take;
  logic [PIX_W-1:0]    nxt_score;
  logic [DIGIT_W-1:0]  nxt_idx;

  assign s_ready      = (state == ST_LOAD);
  assign busy         = (state != ST_LOAD);
  assign beat         = s_valid && s_ready;
  assign at_end       = (wr_cnt == LAST_ADDR);
  assign wdog_expired = (DONE_TIMEOUT != 0) && (wdog == WDOG_LAST);

  // Lane 0 seeds the running best; strict '>' keeps the lower index on ties.
  assign lane      = score_q[idx];
  assign take      = (idx == '0) || (lane > best_score);
  assign nxt_score = take ? lane : best_score;
  assign nxt_idx   = take ? idx : best_idx;

  image_stream_loader_ram #(
    .DEPTH  (NUM_PIXELS),
    .WIDTH  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (beat),
    .waddr (wr_cnt),
    .wdata (s_data),
    .raddr (rd_addr),
    .rq    (rd_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_LOAD;
      wr_cnt       <= '0;
      wdog         <= '0;
      idx          <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      net_start    <= 1'b0;
      frame_err    <= 1'b0;
      timeout_err  <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      result_score <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) score_q[k] <= '0;
    end else begin
      net_start    <= 1'b0;
      frame_err    <= 1'b0;
      timeout_err  <= 1'b0;
      result_valid <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          if (beat) begin
            // A malformed beat is already written; the frame just restarts at 0.
            if (s_last != at_end) begin
              frame_err <= 1'b1;
              wr_cnt    <= '0;
            end else if (s_last) begin
              net_start <= 1'b1;
              wr_cnt    <= wr_cnt + 1'b1;
              state     <= ST_START;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ST_START: begin
          wdog  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          wdog <= wdog + 1'b1;
          if (net_done) begin
            for (int k = 0; k < NUM_CLASSES; k++)
              score_q[k] <= digit_scores[k*PIX_W +: PIX_W];
            idx   <= '0;
            state <= ST_ARGMAX;
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
            wr_cnt      <= '0;
            state       <= ST_LOAD;
          end
        end
        ST_ARGMAX: begin
          best_score <= nxt_score;
          best_idx   <= nxt_idx;
          if (idx == LAST_LANE) begin
            result_digit <= nxt_idx;
            result_score <= nxt_score;
            result_valid <= 1'b1;
            state        <= ST_REPORT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_REPORT: begin
          wr_cnt <= '0;
          state  <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_loader.sv
// Self-checking bench for image_stream_loader: frame loading, read port, argmax table,
// watchdog and reset behaviour, with a result scoreboard driven by a negedge monitor.
module tb_image_stream_loader;
  import image_stream_loader_pkg::*;

  localparam int NP = DEF_NUM_PIXELS;
  localparam int PW = DEF_PIX_W;
  localparam int NC = DEF_NUM_CLASSES;
  localparam int AW = DEF_ADDR_W;
  localparam int TO = 16;
  localparam int NV = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid, s_ready, s_last;
  logic [PW-1:0]     s_data;
  logic [AW-1:0]     rd_addr;
  logic [PW-1:0]     rd_q;
  logic              net_start, net_done;
  logic [NC*PW-1:0]  digit_scores;
  logic              result_valid;
  logic [3:0]        result_digit;
  logic [PW-1:0]     result_score;
  logic              busy, frame_err, timeout_err;

  image_stream_loader #(
    .NUM_PIXELS(NP), .PIX_W(PW), .NUM_CLASSES(NC), .ADDR_W(AW), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .rd_addr(rd_addr), .rd_q(rd_q), .net_start(net_start),
    .net_done(net_done), .digit_scores(digit_scores), .result_valid(result_valid),
    .result_digit(result_digit), .result_score(result_score), .busy(busy),
    .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC*PW-1:0] scores;
    logic [3:0]       digit;
    logic [PW-1:0]    score;
  } vec_t;

  typedef struct {
    logic [3:0]    digit;
    logic [PW-1:0] score;
    int            due;
  } exp_t;

  vec_t          tbl [NV];
  exp_t          res_q [$];
  logic [PW-1:0] rd_exp_q [$];
  exp_t          mon_e;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int n_start = 0, n_ferr = 0, n_terr = 0, n_result = 0;
  int start_cyc = 0, ferr_cyc = 0, terr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (net_start)   begin n_start++; start_cyc = cyc; end
      if (frame_err)   begin n_ferr++;  ferr_cyc  = cyc; end
      if (timeout_err) begin n_terr++;  terr_cyc  = cyc; end
      if (result_valid) begin
        n_result++;
        if (res_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = res_q.pop_front();
          check("result_digit", result_digit, mon_e.digit);
          check("result_score", result_score, mon_e.score);
          check("result_latency", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap_pct,
                            input int offs, output int last_cyc);
    int i, guard;
    logic acc;
    i = 0; guard = 0; last_cyc = -1;
    while (i < n && guard < 20000) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0; s_last = 1'b0;
      end else begin
        s_valid = 1'b1; s_data = PW'(i + offs); s_last = (i == last_at);
      end
      acc = s_valid && s_ready;
      if (acc && i == n - 1) last_cyc = cyc;
      step(1);
      guard++;
      if (acc) i++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (i < n) check("frame_send_stall", i, n);
  endtask

  task automatic read_check(input string name, input int a, input logic [PW-1:0] e);
    logic [PW-1:0] ex;
    rd_addr = AW'(a);
    rd_exp_q.push_back(e);
    step(1);
    ex = rd_exp_q.pop_front();
    check(name, rd_q, ex);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_net_start"}, net_start, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_result_digit"}, result_digit, 0);
    check({tag, "_result_score"}, result_score, 0);
    check({tag, "_rd_q"}, rd_q, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "global timeout");
  end

  initial begin
    int p, r0, s0, f0, t0;
    logic [PW-1:0] ex;

    for (int i = 0; i < NV; i++) tbl[i] = '0;
    tbl[0].scores[9*PW +: PW] = 16'd100;
    tbl[0].scores[3*PW +: PW] = 16'd900;
    tbl[0].scores[7*PW +: PW] = 16'd900;
    tbl[0].digit = 4'd3; tbl[0].score = 16'd900;
    tbl[1].digit = 4'd0; tbl[1].score = 16'd0;
    for (int k = 0; k < NC; k++) tbl[2].scores[k*PW +: PW] = 16'd1;
    tbl[2].scores[9*PW +: PW] = 16'hFFFF;
    tbl[2].digit = 4'd9; tbl[2].score = 16'hFFFF;
    tbl[3].scores[0*PW +: PW] = 16'd5;
    tbl[3].scores[1*PW +: PW] = 16'd5;
    tbl[3].scores[2*PW +: PW] = 16'd4;
    tbl[3].digit = 4'd0; tbl[3].score = 16'd5;
    for (int k = 0; k < NC; k++) tbl[4].scores[k*PW +: PW] = PW'(k * 10);
    tbl[4].digit = 4'd9; tbl[4].score = 16'd90;
    tbl[5].scores[0*PW +: PW] = 16'h0001;
    tbl[5].scores[5*PW +: PW] = 16'h8000;
    tbl[5].scores[6*PW +: PW] = 16'h7FFF;
    tbl[5].digit = 4'd5; tbl[5].score = 16'h8000;

    s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_addr = '0;
    net_done = 1'b0; digit_scores = '0;

    #12;
    check_idle("reset");
    @(negedge clk); rst = 1'b0;
    step(1);

    // Test 1: clean back-to-back frame, start pulse timing, read port.
    s0 = n_start;
    send_frame(NP, NP - 1, 0, 0, p);
    check("t1_net_start", net_start, 1);
    check("t1_s_ready_low", s_ready, 0);
    check("t1_busy", busy, 1);
    read_check("t1_rd500", 500, 16'd500);
    check("t1_start_count", n_start - s0, 1);
    check("t1_start_cycle", start_cyc, p + 1);
    read_check("t1_rd0", 0, 16'd0);
    read_check("t1_rd783", NP - 1, 16'(NP - 1));

    // Test 5: no net_done, watchdog fires 16 cycles after WAIT entry.
    t0 = n_terr;
    for (int k = 0; k < 40 && n_terr == t0; k++) step(1);
    check("t5_timeout_seen", n_terr - t0, 1);
    check("t5_timeout_cycle", terr_cyc, start_cyc + 1 + TO);
    check("t5_s_ready", s_ready, 1);
    check("t5_busy", busy, 0);

    // Single beat with s_last at address 0: read-first on collision, then frame_err.
    f0 = n_ferr;
    s_valid = 1'b1; s_data = 16'hABCD; s_last = 1'b1; rd_addr = '0;
    rd_exp_q.push_back(16'd0);
    step(1);
    s_valid = 1'b0; s_last = 1'b0;
    ex = rd_exp_q.pop_front();
    check("rf_old_data", rd_q, ex);
    check("t3_err_beat0", frame_err, 1);
    read_check("rf_new_data", 0, 16'hABCD);

    // Test 3: early s_last on beat 99.
    s0 = n_start; f0 = n_ferr;
    send_frame(100, 99, 0, 7000, p);
    check("t3_frame_err", frame_err, 1);
    check("t3_no_start", net_start, 0);
    check("t3_s_ready", s_ready, 1);
    step(1);
    check("t3_err_count", n_ferr - f0, 1);
    check("t3_err_cycle", ferr_cyc, p + 1);

    // Missing s_last on the final beat.
    f0 = n_ferr;
    send_frame(NP, -1, 0, 3000, p);
    check("t3_nolast_err", frame_err, 1);
    check("t3_nolast_no_start", net_start, 0);
    step(1);
    check("t3_nolast_count", n_ferr - f0, 1);
    check("t3_total_no_start", n_start - s0, 0);

    // Test 2: same frame with random gaps, full RAM image check.
    s0 = n_start;
    send_frame(NP, NP - 1, 30, 0, p);
    check("t2_net_start", net_start, 1);
    step(1);
    check("t2_start_cycle", start_cyc, p + 1);
    for (int a = 0; a < NP; a++) read_check("t2_ram_image", a, PW'(a));
    check("t2_single_start", n_start - s0, 1);

    // Test 4: argmax vectors through the full start/done/report path.
    for (int i = 0; i < NV; i++) begin
      send_frame(NP, NP - 1, 0, i * 3, p);
      check("t4_start", net_start, 1);
      step(2);
      digit_scores = tbl[i].scores; net_done = 1'b1;
      res_q.push_back('{tbl[i].digit, tbl[i].score, cyc + NC + 1});
      r0 = n_result;
      step(1);
      net_done = 1'b0; digit_scores = {NC{16'hFFFF}};
      for (int k = 0; k < 30 && n_result == r0; k++) step(1);
      check("t4_result_seen", n_result - r0, 1);
      check("t4_busy_after", busy, 0);
      check("t4_valid_low_after", result_valid, 0);
      check("t4_digit_held", result_digit, tbl[i].digit);
      check("t4_score_held", result_score, tbl[i].score);
    end

    // net_done on the very cycle the watchdog expires wins over the timeout.
    t0 = n_terr;
    send_frame(NP, NP - 1, 0, 0, p);
    step(TO);
    digit_scores = tbl[4].scores; net_done = 1'b1;
    res_q.push_back('{tbl[4].digit, tbl[4].score, cyc + NC + 1});
    r0 = n_result;
    step(1);
    net_done = 1'b0; digit_scores = '0;
    for (int k = 0; k < 30 && n_result == r0; k++) step(1);
    check("race_result_seen", n_result - r0, 1);
    check("race_no_timeout", n_terr - t0, 0);

    // Test 6a: reset while in WAIT.
    send_frame(NP, NP - 1, 0, 0, p);
    step(3);
    #2 rst = 1'b1;
    #1 check_idle("rst_wait");
    @(negedge clk); rst = 1'b0;
    step(1);
    r0 = n_result;
    digit_scores = tbl[0].scores; net_done = 1'b1;
    step(1);
    net_done = 1'b0;
    step(15);
    check("rst_wait_done_ignored", n_result - r0, 0);
    check("rst_wait_busy", busy, 0);
    check("rst_wait_s_ready", s_ready, 1);

    // Test 6b: reset mid-LOAD restarts the write counter.
    send_frame(300, -1, 0, 0, p);
    #2 rst = 1'b1;
    #1 check("rst_load_s_ready", s_ready, 1);
    check("rst_load_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    step(1);
    f0 = n_ferr;
    send_frame(NP, NP - 1, 0, 0, p);
    check("rst_load_restart", net_start, 1);
    step(1);
    check("rst_load_no_err", n_ferr - f0, 0);
    check("rst_load_start_cycle", start_cyc, p + 1);
    step(TO + 4);

    check("scoreboard_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
